frame_write_arbiter: RTL

Shares the single CCI TX1 write channel among the three write requesters of the polled driver: frame release (header-clear writes), frame writer (data lines) and status writer (status/doorbell lines). It issues round-robin grants, throttles on TX1 almost-full and on an outstanding-write credit limit, and registers the winning request onto TX1. Each requester must hold its request until granted and advance its state on the grant pulse.

---
 rtl/frame_write_arbiter_pkg.sv | 38 +++
 rtl/frame_write_arbiter_rr_arbiter3.sv | 38 +++
 rtl/frame_write_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/frame_write_arbiter_pkg.sv
// rtl/frame_write_arbiter_pkg.sv - CCI TX1 write-arbiter types and constants
package frame_write_arbiter_pkg;

  localparam int CCI_DATA_WIDTH = 512;

  typedef logic [CCI_DATA_WIDTH-1:0] WrLine;

  typedef struct packed {
    logic [3:0]  req_type;
    logic        sop;
    logic [15:0] mdata;
    logic [41:0] address;
  } tx_header_t;

  typedef struct packed {
    logic request;
  } write_req_t;

  typedef struct packed {
    write_req_t write;
    tx_header_t write_header;
    WrLine      data;
  } frame_arb_t;

  typedef struct packed {
    logic reader_grant;
    logic writer_grant;
    logic status_grant;
  } channel_grant_arb_t;

  typedef enum logic [1:0] {
    LAST_NONE   = 2'd0,
    LAST_READER = 2'd1,
    LAST_WRITER = 2'd2,
    LAST_STATUS = 2'd3
  } last_grant_t;

endpackage

// File: rtl/frame_write_arbiter_rr_arbiter3.sv
// rtl/frame_write_arbiter_rr_arbiter3.sv - three-way round-robin pick, bit 0 first after NONE
module rr_arbiter3
  import frame_write_arbiter_pkg::*;
(
  input  logic [2:0]  request,
  input  logic        enable,
  input  last_grant_t last_grant,
  output logic [2:0]  grant,
  output last_grant_t next_grant
);

  always_comb begin
    int   start;
    int   idx;
    logic found;
    grant      = '0;
    next_grant = last_grant;
    found      = 1'b0;
    idx        = 0;
    case (last_grant)
      LAST_READER: start = 1;
      LAST_WRITER: start = 2;
      default:     start = 0;
    endcase
    if (enable) begin
      for (int k = 0; k < 3; k++) begin
        idx = start + k;
        if (idx >= 3) idx = idx - 3;
        if (!found && request[idx]) begin
          grant[idx] = 1'b1;
          next_grant = last_grant_t'(2'(idx + 1));
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/frame_write_arbiter.sv
// rtl/frame_write_arbiter.sv - shares CCI TX1 among frame release, frame writer and status writer
module frame_write_arbiter
  import frame_write_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING   = 32,
  parameter int unsigned OUTSTANDING_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         resetb,
  input  frame_arb_t                   reader,
  input  frame_arb_t                   writer,
  input  frame_arb_t                   status,
  output channel_grant_arb_t           write_grant,
  input  logic                         tx1_almost_full,
  output tx_header_t                   tx1_header,
  output WrLine                        tx1_data,
  output logic                         tx1_valid,
  input  logic                         rx_write_ack,
  output logic [OUTSTANDING_WIDTH-1:0] outstanding
);

  generate
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 255 ||
        MAX_OUTSTANDING >= (2 ** OUTSTANDING_WIDTH)) begin : g_bad_width
      $error("MAX_OUTSTANDING out of range for OUTSTANDING_WIDTH");
    end
  endgenerate

  localparam logic [OUTSTANDING_WIDTH-1:0] MAX_CNT = OUTSTANDING_WIDTH'(MAX_OUTSTANDING);
  localparam logic [OUTSTANDING_WIDTH-1:0] ONE     = OUTSTANDING_WIDTH'(1);

  last_grant_t last_grant;
  last_grant_t next_grant;
  logic [2:0]  grant;
  logic        issue_ok;
  logic        granted;
  logic        ack_take;
  logic        ack_underflow;

  assign issue_ok = !tx1_almost_full && (outstanding < MAX_CNT);
  assign granted  = |grant;
  // acks arriving with nothing outstanding (e.g. left over from before a reset) are discarded
  assign ack_take = rx_write_ack && (outstanding != '0);

  rr_arbiter3 u_rr (
    .request    ({status.write.request, writer.write.request, reader.write.request}),
    .enable     (issue_ok && resetb),
    .last_grant (last_grant),
    .grant      (grant),
    .next_grant (next_grant)
  );

  assign write_grant = {grant[0], grant[1], grant[2]};

  always_ff @(posedge clk) begin
    if (!resetb) begin
      tx1_valid     <= 1'b0;
      tx1_header    <= '0;
      tx1_data      <= '0;
      outstanding   <= '0;
      last_grant    <= LAST_NONE;
      ack_underflow <= 1'b0;
    end else begin
      tx1_valid     <= granted;
      ack_underflow <= ack_underflow || (rx_write_ack && outstanding == '0);
      if (granted) begin
        last_grant <= next_grant;
        if (grant[0]) begin
          tx1_header <= reader.write_header;
          tx1_data   <= reader.data;
        end else if (grant[1]) begin
          tx1_header <= writer.write_header;
          tx1_data   <= writer.data;
        end else begin
          tx1_header <= status.write_header;
          tx1_data   <= status.data;
        end
      end
      case ({granted, ack_take})
        2'b10:   outstanding <= outstanding + ONE;
        2'b01:   outstanding <= outstanding - ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
